// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, selects the next PC, checks the fetch
// address and fills the IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_LO      = 32'h0000_3000,
  parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] br_target,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        d_has_slot,
  output logic [31:0] pc_f,
  input  logic [31:0] instr_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic [4:0]  exccode_d,
  output logic        bd_d,
  output logic        valid_d
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] seq_pc;
  logic [31:0] sel_pc;
  logic [31:0] redirect_pc;
  logic        redirect;
  logic        fetch_bad;

  assign seq_pc   = pc_f + 32'd4;
  assign redirect = exc_req | eret_req;
  // exc_req beats eret_req when both fire in the same cycle
  assign redirect_pc = exc_req ? HANDLER_PC : epc;

  always_comb begin
    sel_pc = seq_pc;
    case (npc_sel)
      2'd1:    sel_pc = br_target;
      2'd2:    sel_pc = {pc_f[31:28], j_index, 2'b00};
      2'd3:    sel_pc = jr_target;
      default: sel_pc = seq_pc;
    endcase
  end

  // Bad jr targets are only trapped here, once they become the fetch address
  assign fetch_bad = (pc_f[1:0] != 2'b00) || (pc_f < IM_LO) || (pc_f > IM_HI);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_f      <= RESET_PC;
      instr_d   <= 32'h0;
      pc_d      <= 32'h0;
      pc8_d     <= 32'h0;
      exccode_d <= EXC_NONE;
      bd_d      <= 1'b0;
      valid_d   <= 1'b0;
    end else if (redirect) begin
      pc_f      <= redirect_pc;
      instr_d   <= 32'h0;
      pc_d      <= redirect_pc;
      pc8_d     <= redirect_pc + 32'd8;
      exccode_d <= EXC_NONE;
      bd_d      <= 1'b0;
      valid_d   <= 1'b0;
    end else if (!stall) begin
      pc_f      <= sel_pc;
      instr_d   <= fetch_bad ? 32'h0 : instr_f;
      pc_d      <= pc_f;
      pc8_d     <= pc_f + 32'd8;
      exccode_d <= fetch_bad ? EXC_ADEL : EXC_NONE;
      bd_d      <= d_has_slot;
      valid_d   <= 1'b1;
    end
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined MIPS core. It owns the program counter and drives the fetch address into instruction memory. It captures the returned word into the IF/ID pipeline register. It also resolves next-PC selection among sequential, branch, jump, jump-register, exception entry and `eret`. It flags fetch address errors (AdEL) so they travel down the pipe with the offending instruction.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, PC value after reset
- `HANDLER_PC`, 32'h0000_4180, exception entry address
- `IM_LO`, 32'h0000_3000, lowest legal fetch address
- `IM_HI`, 32'h0000_6FFC, highest legal fetch address (4096 words)

Ports:
- `clk`  in  1  the single clock; all state updates on rising edge
- `reset_n`  in  1  reset, synchronous and active-low
- `stall`  in  1  hazard stall from decode; freeze PC and IF/ID
- `npc_sel`  in  2  0 = PC+4, 1 = branch, 2 = j/jal, 3 = jr/jalr
- `br_target`  in  32  branch target computed in ID
- `j_index`  in  26  instr_index field of the j/jal in ID
- `jr_target`  in  32  forwarded rs value for jr/jalr
- `exc_req`  in  1  exception/interrupt accepted by CP0 this cycle
- `eret_req`  in  1  eret committing this cycle
- `epc`  in  32  CP0 EPC
- `d_has_slot`  in  1  instruction in ID is a branch/jump, so the current fetch is its delay slot
- `pc_f`  out  32  fetch address to instruction memory
- `instr_f`  in  32  word returned combinationally by instruction memory
- `instr_d`, `pc_d`, `pc8_d`  out  32 each  IF/ID instruction, its PC, PC+8
- `exccode_d`  out  5  0 = none, 4 = AdEL
- `bd_d`  out  1  IF/ID instruction sits in a delay slot
- `valid_d`  out  1  IF/ID holds a real fetched instruction (0 = bubble)

## Operation
- Next-PC priority, highest first:
  - `exc_req` → `HANDLER_PC`
  - `eret_req` → `epc`
  - `stall` → hold
  - `npc_sel`
- `npc_sel` targets:
  - 1 → `br_target`
  - 2 → {pc_f[31:28], j_index, 2'b00}
  - 3 → `jr_target`
  - 0 → pc_f + 4
- All arithmetic is 32-bit modulo 2^32; no carry is kept.
- Fetch check, combinational on `pc_f`. The fetch is bad if pc_f[1:0] != 0, or pc_f < `IM_LO`, or pc_f > `IM_HI`. A bad fetch captures instr 32'h0 (nop) and exccode 4. A good fetch captures `instr_f` and exccode 0.
- IF/ID update rules, highest priority first:
  - `exc_req` or `eret_req` → flush: instr 0, exccode 0, bd 0, valid 0, pc_d = the new PC.
  - `stall` → hold all fields.
  - Otherwise → load instr/check result, pc_d = pc_f, pc8_d = pc_f + 8, bd_d = `d_has_slot`, valid 1.
- A redirect via `npc_sel` does not flush IF/ID. The delay-slot word fetched in the same cycle is kept.
- `exc_req` and `eret_req` both high: `exc_req` wins.
- `stall` together with `exc_req`/`eret_req`: the redirect wins and the stall is ignored.
- A bad `jr_target` is not trapped at redirect time. It is trapped when fetched.

## Timing
- Reset (reset_n low at edge):
  - pc_f = `RESET_PC`
  - instr_d = 0, pc_d = 0, pc8_d = 0, exccode_d = 0, bd_d = 0, valid_d = 0
  - reset overrides every other input
- Reset held for multiple cycles keeps those values. The first fetch of `RESET_PC` is registered into IF/ID at the first edge with reset_n high.
- `pc_f` is a register output. `instr_f` is sampled in the same cycle, so instruction memory must be combinational read.
- Redirect latency: a select asserted in cycle N gives pc_f = target in cycle N+1.
- Flush is applied at the same edge as the exception/eret redirect.
- Stall: holds exactly as long as `stall` is high; no extra cycle after release.
- No handshake beyond `stall`; every non-stalled cycle consumes one fetch.

## Test plan
- Reset then run: reset_n low 2 cycles, then high, code at 0x3000. Required: pc_f = 0x3000, then 0x3004, 0x3008. Then instr_d = word@0x3000 with pc_d = 0x3000, pc8_d = 0x3008, valid_d = 1.
- Branch with delay slot: beq in ID at 0x3004, npc_sel = 1, br_target = 0x3020, d_has_slot = 1. Required: IF/ID gets word@0x3008 with bd_d = 1, then pc_f = 0x3020.
- Stall: stall high 3 cycles at pc_f = 0x3010. Required: pc_f and all IF/ID outputs frozen for 3 cycles, then pc_f = 0x3014 on the next edge.
- Exception vs eret: exc_req and eret_req high together, epc = 0x3040, stall = 1. Required: pc_f = 0x4180 and instr_d = 0, valid_d = 0. With eret_req alone: pc_f = 0x3040 and a flushed IF/ID.
- Address errors: jr_target = 0x3002, then separately 0x7000. Required each time: instr_d = 0, exccode_d = 4, pc_d = the bad address, valid_d = 1.
- Reset mid-stall: reset_n low while stall = 1 and exc_req = 1. Required: pc_f = 0x3000, all IF/ID outputs 0.
